gpu_regb_arb: RTL and testbench

Write-back and host-access arbiter for port B of the GPU's 64x32 register file. It multiplexes three requesters onto the single B port: ALU result write-back, memory-load write-back (through a small queue) and host register access. It also keeps a pending-load scoreboard so the issue logic can stall on registers with outstanding loads. It sits between the GPU execution units and the register file's B-side pins (nweb/clkb/ab/db/qb).

---
 rtl/gpu_regb_arb.sv | 244 ++++++++++++++++++++++++
 tb/tb_gpu_regb_arb.sv | 391 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_regb_arb.sv
// gpu_regb_arb: port-B arbiter for the 64x32 GPU register file.
// Multiplexes ALU write-back, queued load write-back and host register
// access onto the single B port. It also tracks a pending-load scoreboard
// that the issue logic uses to stall on registers with outstanding loads.
module gpu_regb_arb #(
    parameter int AW       = 6,
    parameter int DW       = 32,
    parameter int LQ_DEPTH = 2
) (
    input  logic          sys_clk,
    input  logic          rst,
    // ALU write-back, always accepted
    input  logic          alu_we,
    input  logic [AW-1:0] alu_reg,
    input  logic [DW-1:0] alu_data,
    // load return
    input  logic          ld_valid,
    input  logic [AW-1:0] ld_reg,
    input  logic [DW-1:0] ld_data,
    output logic          ld_ready,
    // load issue / scoreboard
    input  logic          ld_issue,
    input  logic [AW-1:0] ld_issue_reg,
    input  logic [AW-1:0] sb_query_reg,
    output logic          sb_busy,
    // host access
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_reg,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    // register file port B
    output logic          ram_clkb,
    output logic          ram_nweb,
    output logic [AW-1:0] ram_ab,
    output logic [DW-1:0] ram_db,
    input  logic [DW-1:0] ram_qb
);

    localparam int NREG = 1 << AW;
    localparam int PW   = (LQ_DEPTH > 1) ? $clog2(LQ_DEPTH) : 1;
    localparam int CW   = $clog2(LQ_DEPTH + 1);

    typedef enum logic [1:0] {
        G_NONE,
        G_ALU,
        G_LOAD,
        G_HOST
    } grant_t;

    typedef enum logic [1:0] {
        H_IDLE,
        H_RDLAT,
        H_ACK
    } hstate_t;

    // ------------------------------------------------------------------
    // Load write-back queue
    // ------------------------------------------------------------------
    logic [AW-1:0] r_lq_reg  [LQ_DEPTH];
    logic [DW-1:0] r_lq_data [LQ_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [PW-1:0] w_wr_ptr_next;
    logic [PW-1:0] w_rd_ptr_next;
    logic          w_lq_nempty;
    logic          w_push;
    logic          w_pop;
    logic [AW-1:0] w_head_reg;
    logic [DW-1:0] w_head_data;

    // ------------------------------------------------------------------
    // Host side and grant
    // ------------------------------------------------------------------
    hstate_t       r_hstate;
    logic          r_host_ack;
    logic [DW-1:0] r_host_rdata;
    logic [1:0]    r_host_age;
    logic          w_host_elig;
    grant_t        w_grant;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
    logic [NREG-1:0] r_pending;
    logic [NREG-1:0] w_set_mask;
    logic [NREG-1:0] w_clr_mask;

    // Full queue refuses new loads even if the head drains this cycle; this
    // keeps ld_ready a pure function of registered state.
    assign ld_ready    = (r_count != CW'(LQ_DEPTH));
    assign w_lq_nempty = (r_count != '0);
    assign w_push      = ld_valid & ld_ready;
    assign w_pop       = (w_grant == G_LOAD);
    assign w_head_reg  = r_lq_reg[r_rd_ptr];
    assign w_head_data = r_lq_data[r_rd_ptr];

    assign w_wr_ptr_next = (r_wr_ptr == PW'(LQ_DEPTH - 1)) ? '0 : r_wr_ptr + PW'(1);
    assign w_rd_ptr_next = (r_rd_ptr == PW'(LQ_DEPTH - 1)) ? '0 : r_rd_ptr + PW'(1);

    assign w_host_elig = host_req & (r_hstate == H_IDLE);

    // Fixed-priority grant; the starved host jumps ahead of the load queue.
    // Reset also suppresses every grant so the port is quiet while rst is high.
    always_comb begin
        w_grant = G_NONE;
        if (!rst) begin
            if (alu_we)
                w_grant = G_ALU;
            else if (w_host_elig && (r_host_age == 2'd3))
                w_grant = G_HOST;
            else if (w_lq_nempty)
                w_grant = G_LOAD;
            else if (w_host_elig)
                w_grant = G_HOST;
        end
    end

    // Drive port B from whichever requester won this cycle.
    always_comb begin
        ram_clkb = 1'b0;
        ram_nweb = 1'b1;
        ram_ab   = '0;
        ram_db   = '0;
        case (w_grant)
            G_ALU: begin
                ram_clkb = 1'b1;
                ram_nweb = 1'b0;
                ram_ab   = alu_reg;
                ram_db   = alu_data;
            end
            G_LOAD: begin
                ram_clkb = 1'b1;
                ram_nweb = 1'b0;
                ram_ab   = w_head_reg;
                ram_db   = w_head_data;
            end
            G_HOST: begin
                ram_clkb = 1'b1;
                ram_nweb = ~host_we;
                ram_ab   = host_reg;
                ram_db   = host_we ? host_wdata : '0;
            end
            default: ;
        endcase
    end

    // Queue payload storage; no reset needed, validity lives in r_count.
    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_lq_reg[r_wr_ptr]  <= ld_reg;
            r_lq_data[r_wr_ptr] <= ld_data;
        end
    end

    // Queue pointers and occupancy; reset discards any queued loads.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= w_wr_ptr_next;
            if (w_pop)
                r_rd_ptr <= w_rd_ptr_next;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: ;
            endcase
        end
    end

    // One-hot set/clear masks per register for the scoreboard update.
    generate
        for (genvar gi = 0; gi < NREG; gi++) begin : g_sb_mask
            assign w_set_mask[gi] = ld_issue & (ld_issue_reg == AW'(gi));
            assign w_clr_mask[gi] = w_pop & (w_head_reg == AW'(gi));
        end
    endgenerate

    // Pending-load vector; a same-cycle issue beats the clearing write-back.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            r_pending <= '0;
        else
            r_pending <= (r_pending & ~w_clr_mask) | w_set_mask;
    end

    assign sb_busy = r_pending[sb_query_reg];

    // Host transaction FSM with registered ack and read data.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_hstate     <= H_IDLE;
            r_host_ack   <= 1'b0;
            r_host_rdata <= '0;
        end else begin
            r_host_ack <= 1'b0;
            case (r_hstate)
                H_IDLE: begin
                    if (w_grant == G_HOST) begin
                        if (host_we) begin
                            r_hstate   <= H_ACK;
                            r_host_ack <= 1'b1;
                        end else begin
                            r_hstate <= H_RDLAT;
                        end
                    end
                end
                H_RDLAT: begin
                    // RAM read data is valid the cycle after the read grant.
                    r_host_rdata <= ram_qb;
                    r_hstate     <= H_ACK;
                    r_host_ack   <= 1'b1;
                end
                H_ACK: begin
                    r_hstate <= H_IDLE;
                end
                default: begin
                    r_hstate <= H_IDLE;
                end
            endcase
        end
    end

    // Starvation counter: only losses to the load queue age the host.
    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst)
            r_host_age <= 2'd0;
        else if (!host_req || (w_grant == G_HOST))
            r_host_age <= 2'd0;
        else if (w_host_elig && (w_grant == G_LOAD) && (r_host_age != 2'd3))
            r_host_age <= r_host_age + 2'd1;
    end

    assign host_ack   = r_host_ack;
    assign host_rdata = r_host_rdata;

endmodule

// File: tb/tb_gpu_regb_arb.sv
// Testbench for gpu_regb_arb: directed scenarios plus randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_gpu_regb_arb;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          sys_clk = 1'b0;
    logic          rst;
    logic          alu_we;
    logic [AW-1:0] alu_reg;
    logic [DW-1:0] alu_data;
    logic          ld_valid;
    logic [AW-1:0] ld_reg;
    logic [DW-1:0] ld_data;
    logic          ld_ready;
    logic          ld_issue;
    logic [AW-1:0] ld_issue_reg;
    logic [AW-1:0] sb_query_reg;
    logic          sb_busy;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_reg;
    logic [DW-1:0] host_wdata;
    logic          host_ack;
    logic [DW-1:0] host_rdata;
    logic          ram_clkb;
    logic          ram_nweb;
    logic [AW-1:0] ram_ab;
    logic [DW-1:0] ram_db;
    logic [DW-1:0] ram_qb;

    always #5 sys_clk = ~sys_clk;

    gpu_regb_arb #(.AW(AW), .DW(DW), .LQ_DEPTH(2)) dut (
        .sys_clk      (sys_clk),
        .rst          (rst),
        .alu_we       (alu_we),
        .alu_reg      (alu_reg),
        .alu_data     (alu_data),
        .ld_valid     (ld_valid),
        .ld_reg       (ld_reg),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .ld_issue     (ld_issue),
        .ld_issue_reg (ld_issue_reg),
        .sb_query_reg (sb_query_reg),
        .sb_busy      (sb_busy),
        .host_req     (host_req),
        .host_we      (host_we),
        .host_reg     (host_reg),
        .host_wdata   (host_wdata),
        .host_ack     (host_ack),
        .host_rdata   (host_rdata),
        .ram_clkb     (ram_clkb),
        .ram_nweb     (ram_nweb),
        .ram_ab       (ram_ab),
        .ram_db       (ram_db),
        .ram_qb       (ram_qb)
    );

    // Register file port B as seen by the arbiter: sync write, registered read.
    logic [DW-1:0] ram_mem [64];
    always @(posedge sys_clk) begin
        if (ram_clkb) begin
            if (!ram_nweb) ram_mem[ram_ab] <= ram_db;
            else           ram_qb <= ram_mem[ram_ab];
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [AW-1:0] r;
        logic [DW-1:0] d;
    } ld_t;

    ld_t           mq[$];
    bit [63:0]     m_pend;
    int            m_hph;       // 0 idle, 1 waiting for read data, 2 ack
    int            m_age;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_rd_val;
    logic [DW-1:0] m_mem [64];
    int            m_who;       // 0 none, 1 alu, 2 load, 3 host
    bit            host_done;

    task automatic model_reset();
        mq.delete();
        m_pend  = '0;
        m_hph   = 0;
        m_age   = 0;
        m_rdata = '0;
    endtask

    // Decide this cycle's winner from the rules and compare every output.
    task automatic settle();
        bit            elig;
        logic          e_clkb, e_nweb;
        logic [AW-1:0] e_ab;
        logic [DW-1:0] e_db;
        #1;
        elig = host_req && (m_hph == 0);
        if (rst)                          m_who = 0;
        else if (alu_we)                  m_who = 1;
        else if (elig && m_age >= 3)      m_who = 3;
        else if (mq.size() > 0)           m_who = 2;
        else if (elig)                    m_who = 3;
        else                              m_who = 0;
        e_clkb = (m_who != 0);
        e_nweb = 1'b1;
        e_ab   = '0;
        e_db   = '0;
        if (m_who == 1) begin e_nweb = 1'b0; e_ab = alu_reg; e_db = alu_data; end
        if (m_who == 2) begin e_nweb = 1'b0; e_ab = mq[0].r; e_db = mq[0].d; end
        if (m_who == 3) begin
            e_nweb = !host_we;
            e_ab   = host_reg;
            e_db   = host_we ? host_wdata : '0;
        end
        check("ram_clkb",   ram_clkb,   e_clkb);
        check("ram_nweb",   ram_nweb,   e_nweb);
        check("ram_ab",     ram_ab,     e_ab);
        check("ram_db",     ram_db,     e_db);
        check("ld_ready",   ld_ready,   (mq.size() < 2));
        check("sb_busy",    sb_busy,    m_pend[sb_query_reg]);
        check("host_ack",   host_ack,   (m_hph == 2));
        check("host_rdata", host_rdata, m_rdata);
    endtask

    // Advance the model across the rising edge, then return at the falling edge.
    task automatic tick();
        bit  elig;
        bit  rdy;
        ld_t e;
        @(posedge sys_clk);
        if (rst) begin
            model_reset();
            host_done = 0;
        end else begin
            elig      = host_req && (m_hph == 0);
            rdy       = (mq.size() < 2);
            host_done = (m_hph == 2);
            case (m_who)
                1: m_mem[alu_reg] = alu_data;
                2: m_mem[mq[0].r] = mq[0].d;
                3: if (host_we) m_mem[host_reg] = host_wdata;
                   else         m_rd_val = m_mem[host_reg];
                default: ;
            endcase
            if (m_who == 2) m_pend[mq[0].r] = 1'b0;
            if (ld_issue)   m_pend[ld_issue_reg] = 1'b1;
            if (m_who == 2) void'(mq.pop_front());
            if (ld_valid && rdy) begin
                e.r = ld_reg;
                e.d = ld_data;
                mq.push_back(e);
            end
            if (!host_req || m_who == 3)            m_age = 0;
            else if (elig && m_who == 2 && m_age < 3) m_age++;
            case (m_hph)
                0: if (m_who == 3) m_hph = host_we ? 2 : 1;
                1: begin m_rdata = m_rd_val; m_hph = 2; end
                default: m_hph = 0;
            endcase
        end
        @(negedge sys_clk);
    endtask

    task automatic cycle();
        settle();
        tick();
    endtask

    task automatic idle();
        alu_we   = 1'b0;
        ld_valid = 1'b0;
        ld_issue = 1'b0;
        host_req = 1'b0;
    endtask

    task automatic drive_random();
        alu_we       = ($urandom % 4) == 0;
        alu_reg      = 6'($urandom_range(0, 15));
        alu_data     = $urandom;
        ld_valid     = ($urandom % 2) == 1;
        ld_reg       = 6'($urandom_range(0, 15));
        ld_data      = $urandom;
        ld_issue     = ($urandom % 3) == 0;
        ld_issue_reg = 6'($urandom_range(0, 15));
        sb_query_reg = 6'($urandom_range(0, 15));
        if (host_req && host_done)
            host_req = 1'b0;
        else if (!host_req && ($urandom % 5) == 0) begin
            host_req   = 1'b1;
            host_we    = ($urandom % 2) == 1;
            host_reg   = 6'($urandom_range(0, 15));
            host_wdata = $urandom;
        end
    endtask

    initial begin
        int got;
        rst = 1'b1;
        idle();
        alu_reg = '0; alu_data = '0; ld_reg = '0; ld_data = '0;
        ld_issue_reg = '0; sb_query_reg = '0;
        host_we = 1'b0; host_reg = '0; host_wdata = '0;
        ram_qb = '0;
        host_done = 0;
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = '0;
            m_mem[i]   = '0;
        end
        model_reset();
        @(negedge sys_clk);

        // Reset values
        settle();
        check("rst_ld_ready", ld_ready, 1);
        check("rst_nweb",     ram_nweb, 1);
        check("rst_clkb",     ram_clkb, 0);
        tick();
        cycle();
        rst = 1'b0;

        // ALU/load collision on r5
        idle();
        alu_we = 1; alu_reg = 5; alu_data = 32'h11111111;
        ld_valid = 1; ld_reg = 5; ld_data = 32'h22222222;
        settle();
        check("coll_alu_db", ram_db, 32'h11111111);
        tick();
        idle();
        settle();
        check("coll_ld_ab", ram_ab, 5);
        check("coll_ld_db", ram_db, 32'h22222222);
        tick();
        cycle();
        check("coll_r5", ram_mem[5], 32'h22222222);

        // Queue full under continuous ALU traffic, then drain in order
        idle();
        alu_we = 1; alu_reg = 40; alu_data = 32'h0BADF00D;
        ld_valid = 1; ld_reg = 20; ld_data = 32'hA0A0A020;
        cycle();
        ld_reg = 21; ld_data = 32'hA0A0A021;
        cycle();
        ld_reg = 22; ld_data = 32'hA0A0A022;
        settle();
        check("qfull_ready", ld_ready, 0);
        tick();
        idle();
        settle();
        check("drain0_ab", ram_ab, 20);
        check("drain0_db", ram_db, 32'hA0A0A020);
        tick();
        settle();
        check("drain1_ab", ram_ab, 21);
        tick();
        settle();
        check("drain_ready", ld_ready, 1);
        check("drain_empty", ram_clkb, 0);
        tick();

        // Host read of r10 on an idle bus
        alu_we = 1; alu_reg = 10; alu_data = 32'hDEADBEEF;
        cycle();
        idle();
        cycle();
        host_req = 1; host_we = 0; host_reg = 10;
        settle();
        check("hrd_grant_nweb", ram_nweb, 1);
        check("hrd_grant_ab",   ram_ab, 10);
        tick();
        settle();
        check("hrd_ack_g1", host_ack, 0);
        tick();
        settle();
        check("hrd_ack_g2", host_ack, 1);
        check("hrd_rdata",  host_rdata, 32'hDEADBEEF);
        tick();
        host_req = 0;
        cycle();

        // Host starvation by a continuously fed load queue
        idle();
        ld_valid = 1; ld_reg = 6'(32 + $urandom_range(0, 31)); ld_data = $urandom;
        cycle();
        ld_reg = 6'(32 + $urandom_range(0, 31)); ld_data = $urandom;
        cycle();
        host_req = 1; host_we = 1; host_reg = 3; host_wdata = 32'hCAFEF00D;
        got = 0;
        for (int k = 1; k <= 8; k++) begin
            ld_reg  = 6'(32 + $urandom_range(0, 31));
            ld_data = $urandom;
            settle();
            if (got == 0 && ram_clkb && !ram_nweb && ram_ab == 6'd3) got = k;
            tick();
            if (host_done) host_req = 0;
        end
        idle();
        repeat (4) cycle();
        check("starve_grant_cycle", got, 4);
        check("starve_r3", ram_mem[3], 32'hCAFEF00D);

        // Scoreboard set, clear, and set-beats-clear
        idle();
        sb_query_reg = 7;
        ld_issue = 1; ld_issue_reg = 7;
        settle();
        check("sb_before", sb_busy, 0);
        tick();
        idle();
        settle();
        check("sb_set", sb_busy, 1);
        tick();
        ld_valid = 1; ld_reg = 7; ld_data = 32'h77777777;
        cycle();
        idle();
        cycle();
        settle();
        check("sb_cleared", sb_busy, 0);
        tick();
        ld_issue = 1; ld_issue_reg = 7;
        cycle();
        idle();
        ld_valid = 1; ld_reg = 7; ld_data = 32'h77770000;
        cycle();
        idle();
        ld_issue = 1; ld_issue_reg = 7;
        cycle();
        idle();
        settle();
        check("sb_same_cycle", sb_busy, 1);
        tick();

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            drive_random();
            cycle();
        end
        idle();
        repeat (4) cycle();

        // Reset in the middle of a host read with a full load queue
        alu_we = 1; alu_reg = 50; alu_data = $urandom;
        ld_valid = 1; ld_reg = 51; ld_data = $urandom;
        host_req = 1; host_we = 0; host_reg = 10;
        cycle();
        ld_reg = 52;
        cycle();
        alu_we = 0; ld_valid = 0;
        cycle();
        settle();
        rst = 1'b1;
        #1;
        check("mrst_ld_ready", ld_ready, 1);
        check("mrst_sb_busy",  sb_busy, 0);
        check("mrst_host_ack", host_ack, 0);
        check("mrst_rdata",    host_rdata, 0);
        check("mrst_clkb",     ram_clkb, 0);
        check("mrst_nweb",     ram_nweb, 1);
        check("mrst_ab",       ram_ab, 0);
        check("mrst_db",       ram_db, 0);
        idle();
        tick();
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            settle();
            check("post_rst_no_ack", host_ack, 0);
            check("post_rst_no_drain", ram_clkb, 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
